control_fsm: RTL and testbench
==============================

CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 Parameter XLEN, default 32, datapath width; sets imm width; legal values 32 or 64.
REQ-002 Parameter RET_W, default 32, width of the retired-instruction counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 inst_valid  input  1  instruction word from fetch is valid.
REQ-006 inst_ready  output  1  block accepts an instruction this cycle.
REQ-007 inst  input  32  instruction word.
REQ-008 rd, rs1, rs2  output  5 each  register indices, taken from IR[11:7], IR[19:15] and IR[24:20].
REQ-009 type  output  3  instruction class: 0 none, 1 I, 2 U, 3 J.
REQ-010 aluc  output  4  ALU operation: 0 ADD, 1 SLT, 2 SLTU, 3 XOR, 4 OR, 5 AND, 6 SLL, 7 SRL, 8 SRA, 9 PASSB.
REQ-011 m1  output  1  ALU operand B select: 1 imm, 0 rs2.
REQ-012 m2  output  1  ALU operand A select: 1 pc, 0 rs1.
REQ-013 wb_sel  output  1  writeback source: 0 ALU result, 1 pc+4.
REQ-014 imm  output  XLEN  sign-extended immediate.
REQ-015 reg_we  output  1  register-file write strobe.
REQ-016 pc_we  output  1  PC update strobe.
REQ-017 jump  output  1  PC takes the ALU result instead of pc+4.
REQ-018 halt  output  1  core stopped.
REQ-019 illegal  output  1  the stop was caused by an unsupported encoding.
REQ-020 retired  output  RET_W  count of completed instructions.

Function
REQ-021 The FSM SHALL use states FETCH, DECODE, EXEC, WB and HALT, and SHALL leave reset in FETCH.
REQ-022 inst_ready SHALL be 1 only in FETCH.
REQ-023 When inst_valid and inst_ready are both 1 at a rising edge, the block SHALL latch inst into the internal IR and go to DECODE; otherwise it SHALL stay in FETCH.
REQ-024 inst_valid SHALL be ignored outside FETCH, and inst SHALL not affect any output outside the accepting edge.
REQ-025 All decode outputs (rd, rs1, rs2, type, aluc, m1, m2, wb_sel, imm, jump) SHALL be derived from IR only and SHALL hold stable from DECODE through WB.
REQ-026 OP-IMM (opcode 0010011) decode:
- type=I, m1=1, m2=0, wb_sel=0
- funct3 000/010/011/100/110/111 SHALL map to ADD/SLT/SLTU/XOR/OR/AND
- funct3 001 with funct7 0000000 SHALL map to SLL
- funct3 101 with funct7 0000000 SHALL map to SRL; with funct7 0100000 SHALL map to SRA
- any other funct7 on a shift SHALL be illegal
- for XLEN=64, shifts SHALL use the 6-bit shamt IR[25:20] and check IR[31:26] instead of funct7.
REQ-027 LUI SHALL decode as type=U, aluc=PASSB, m1=1; AUIPC SHALL decode as type=U, aluc=ADD, m1=1, m2=1.
REQ-028 JAL SHALL decode as type=J, aluc=ADD, m1=1, m2=1, wb_sel=1, jump=1; JALR (funct3 000) SHALL decode as type=I, aluc=ADD, m1=1, m2=0, wb_sel=1, jump=1.
REQ-029 imm SHALL be the I-, U- or J-format immediate sign-extended from IR[31] to XLEN; it SHALL be 0 for type none.
REQ-030 DECODE SHALL go to EXEC on a legal instruction.
REQ-031 EBREAK (0x00100073) in DECODE SHALL go to HALT with illegal=0.
REQ-032 Any other encoding in DECODE SHALL go to HALT with illegal=1.
REQ-033 EXEC SHALL last exactly one cycle and then go to WB.
REQ-034 In WB, pc_we SHALL be 1 for exactly one cycle.
REQ-035 In WB, reg_we SHALL be 1 for exactly one cycle only if rd != 0.
REQ-036 In WB, retired SHALL increment by 1 and wrap from 2^RET_W-1 to 0; the next state SHALL be FETCH.
REQ-037 Latency SHALL be 3 cycles from the accepting edge to the reg_we/pc_we cycle; throughput SHALL be at most one instruction per 4 cycles.
REQ-038 HALT SHALL be absorbing:
- halt=1
- inst_ready=0, reg_we=0, pc_we=0
- retired frozen
- exit only through reset.
REQ-039 EBREAK and illegal instructions SHALL not increment retired.

Reset
REQ-040 When rst_n=0 at a rising edge, in any state including mid-instruction, the next state SHALL be FETCH and IR SHALL be cleared to 0.
REQ-041 Reset values: inst_ready=1 (FETCH), reg_we=0, pc_we=0, jump=0, halt=0, illegal=0, retired=0, type=0, imm=0.
REQ-042 An instruction interrupted by reset SHALL produce no reg_we or pc_we pulse and SHALL not be counted.

Verification
REQ-043 addi x5,x0,-1 (0xFFF00293) accepted at edge N -> reg_we=1 and pc_we=1 in cycle N+3 only; rd=5, aluc=0, m1=1, imm=all ones (XLEN); retired 0->1.
REQ-044 inst_valid held 0 for 10 cycles, then asserted -> inst_ready stays 1 throughout and the instruction is accepted on the first edge where inst_valid=1.
REQ-045 srai x1,x1,3 (0x4030D093) -> aluc=8; same encoding with funct7 0100001 -> halt=1, illegal=1, retired unchanged.
REQ-046 jal x1,+8 (0x008000EF) -> type=3, jump=1, wb_sel=1, m2=1, imm=8; addi x0,x0,0 -> reg_we=0, pc_we=1.
REQ-047 ebreak (0x00100073) -> halt=1, illegal=0; inst_valid pulses for 20 cycles -> no accept; then rst_n=0 for one edge -> FETCH, retired=0.
REQ-048 rst_n=0 asserted in EXEC -> no WB pulses; with retired preset to 2^RET_W-1, one further addi -> retired wraps to 0.

Source files
------------

// File: rtl/control_fsm.sv
// Sequencer for a small RV-style instruction subset (OP-IMM, LUI, AUIPC, JAL, JALR).
// One instruction in flight: FETCH -> DECODE -> EXEC -> WB; EBREAK or a bad encoding parks in HALT.
module control_fsm #(
  parameter int XLEN  = 32,
  parameter int RET_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_inst_valid,
  output logic             o_inst_ready,
  input  logic [31:0]      i_inst,
  output logic [4:0]       o_rd,
  output logic [4:0]       o_rs1,
  output logic [4:0]       o_rs2,
  output logic [2:0]       o_type,
  output logic [3:0]       o_aluc,
  output logic             o_m1,
  output logic             o_m2,
  output logic             o_wb_sel,
  output logic [XLEN-1:0]  o_imm,
  output logic             o_reg_we,
  output logic             o_pc_we,
  output logic             o_jump,
  output logic             o_halt,
  output logic             o_illegal,
  output logic [RET_W-1:0] o_retired
);

  // state | meaning
  // FETCH  | waiting for an instruction word
  // DECODE | IR decoded, legality checked
  // EXEC   | ALU cycle
  // WB     | register/PC write strobes, retire
  // HALT   | stopped until reset
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JLR = 7'b1100111;

  localparam logic [2:0] T_NONE = 3'd0;
  localparam logic [2:0] T_I    = 3'd1;
  localparam logic [2:0] T_U    = 3'd2;
  localparam logic [2:0] T_J    = 3'd3;

  localparam logic [3:0] A_ADD  = 4'd0;
  localparam logic [3:0] A_SLT  = 4'd1;
  localparam logic [3:0] A_SLTU = 4'd2;
  localparam logic [3:0] A_XOR  = 4'd3;
  localparam logic [3:0] A_OR   = 4'd4;
  localparam logic [3:0] A_AND  = 4'd5;
  localparam logic [3:0] A_SLL  = 4'd6;
  localparam logic [3:0] A_SRL  = 4'd7;
  localparam logic [3:0] A_SRA  = 4'd8;
  localparam logic [3:0] A_PASB = 4'd9;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [31:0]      r_ir;
  logic             r_illegal;
  logic [RET_W-1:0] r_retired;

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic       w_sh_zero;
  logic       w_sh_arith;
  logic       w_ebreak;
  logic       w_legal;
  logic [2:0] w_type;
  logic [3:0] w_aluc;
  logic       w_m1;
  logic       w_m2;
  logic       w_wb_sel;
  logic       w_jump;

  assign w_opcode = r_ir[6:0];
  assign w_funct3 = r_ir[14:12];
  assign w_ebreak = (r_ir == 32'h0010_0073);

  // RV64 shifts borrow IR[25] for shamt, so only IR[31:26] carries the funct bits.
  assign w_sh_zero  = (XLEN == 64) ? (r_ir[31:26] == 6'b000000) : (r_ir[31:25] == 7'b0000000);
  assign w_sh_arith = (XLEN == 64) ? (r_ir[31:26] == 6'b010000) : (r_ir[31:25] == 7'b0100000);

  always_comb begin
    w_type   = T_NONE;
    w_aluc   = A_ADD;
    w_m1     = 1'b0;
    w_m2     = 1'b0;
    w_wb_sel = 1'b0;
    w_jump   = 1'b0;
    w_legal  = 1'b0;
    case (w_opcode)
      OP_IMM: begin
        w_type  = T_I;
        w_m1    = 1'b1;
        w_legal = 1'b1;
        case (w_funct3)
          3'b000: w_aluc = A_ADD;
          3'b010: w_aluc = A_SLT;
          3'b011: w_aluc = A_SLTU;
          3'b100: w_aluc = A_XOR;
          3'b110: w_aluc = A_OR;
          3'b111: w_aluc = A_AND;
          3'b001: begin
            w_aluc  = A_SLL;
            w_legal = w_sh_zero;
          end
          default: begin
            w_aluc  = w_sh_arith ? A_SRA : A_SRL;
            w_legal = w_sh_zero | w_sh_arith;
          end
        endcase
      end
      OP_LUI: begin
        w_type  = T_U;
        w_aluc  = A_PASB;
        w_m1    = 1'b1;
        w_legal = 1'b1;
      end
      OP_AUI: begin
        w_type  = T_U;
        w_m1    = 1'b1;
        w_m2    = 1'b1;
        w_legal = 1'b1;
      end
      OP_JAL: begin
        w_type   = T_J;
        w_m1     = 1'b1;
        w_m2     = 1'b1;
        w_wb_sel = 1'b1;
        w_jump   = 1'b1;
        w_legal  = 1'b1;
      end
      OP_JLR: begin
        if (w_funct3 == 3'b000) begin
          w_type   = T_I;
          w_m1     = 1'b1;
          w_wb_sel = 1'b1;
          w_jump   = 1'b1;
          w_legal  = 1'b1;
        end
      end
      default: ;
    endcase
    if (!w_legal) begin
      w_type   = T_NONE;
      w_aluc   = A_ADD;
      w_m1     = 1'b0;
      w_m2     = 1'b0;
      w_wb_sel = 1'b0;
      w_jump   = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_FETCH;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FETCH:  if (i_inst_valid) w_state_nxt = S_DECODE;
      S_DECODE: w_state_nxt = (w_legal && !w_ebreak) ? S_EXEC : S_HALT;
      S_EXEC:   w_state_nxt = S_WB;
      S_WB:     w_state_nxt = S_FETCH;
      S_HALT:   w_state_nxt = S_HALT;
      default:  w_state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    o_inst_ready = (r_state == S_FETCH);
    o_pc_we      = (r_state == S_WB);
    o_reg_we     = (r_state == S_WB) && (r_ir[11:7] != 5'd0);
    o_halt       = (r_state == S_HALT);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_ir      <= '0;
      r_illegal <= 1'b0;
      r_retired <= '0;
    end else begin
      if (r_state == S_FETCH && i_inst_valid) r_ir <= i_inst;
      if (r_state == S_DECODE && !w_legal && !w_ebreak) r_illegal <= 1'b1;
      if (r_state == S_WB) r_retired <= r_retired + RET_W'(1);
    end
  end

  always_comb begin
    case (w_type)
      T_I:     o_imm = XLEN'($signed(r_ir[31:20]));
      T_U:     o_imm = XLEN'($signed({r_ir[31:12], 12'h000}));
      T_J:     o_imm = XLEN'($signed({r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0}));
      default: o_imm = '0;
    endcase
  end

  assign o_rd      = r_ir[11:7];
  assign o_rs1     = r_ir[19:15];
  assign o_rs2     = r_ir[24:20];
  assign o_type    = w_type;
  assign o_aluc    = w_aluc;
  assign o_m1      = w_m1;
  assign o_m2      = w_m2;
  assign o_wb_sel  = w_wb_sel;
  assign o_jump    = w_jump;
  assign o_illegal = r_illegal;
  assign o_retired = r_retired;

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm: decode fields, WB pulse timing, halt/illegal, reset and retire wrap.
// RET_W is narrowed to 3 so the retire counter wraps after a handful of instructions.
module tb_control_fsm;
  localparam int XLEN  = 32;
  localparam int RET_W = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             inst_valid = 1'b0;
  logic [31:0]      inst = 32'h0;
  logic             inst_ready;
  logic [4:0]       rd, rs1, rs2;
  logic [2:0]       typ;
  logic [3:0]       aluc;
  logic             m1, m2, wb_sel;
  logic [XLEN-1:0]  imm;
  logic             reg_we, pc_we, jump, halt, illegal;
  logic [RET_W-1:0] retired;

  int n_chk = 0;
  int n_bad = 0;

  control_fsm #(.XLEN(XLEN), .RET_W(RET_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_inst_valid(inst_valid), .o_inst_ready(inst_ready),
    .i_inst(inst), .o_rd(rd), .o_rs1(rs1), .o_rs2(rs2), .o_type(typ), .o_aluc(aluc),
    .o_m1(m1), .o_m2(m2), .o_wb_sel(wb_sel), .o_imm(imm), .o_reg_we(reg_we),
    .o_pc_we(pc_we), .o_jump(jump), .o_halt(halt), .o_illegal(illegal), .o_retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one instruction and follow it through DECODE/EXEC/WB; inst_valid stays high and
  // inst is scrambled while busy, which must have no effect.
  task automatic run_inst(input string tag, input logic [31:0] ins, input logic exp_rwe);
    @(negedge clk);
    inst_valid = 1'b1;
    inst       = ins;
    chk({tag, ":ready"}, inst_ready, 1);
    @(posedge clk);
    #1 inst = 32'hDEAD_BEEF;
    @(negedge clk);
    chk({tag, ":dec_we"}, {reg_we, pc_we}, 2'b00);
    @(negedge clk);
    chk({tag, ":exe_we"}, {reg_we, pc_we}, 2'b00);
    @(negedge clk);
    chk({tag, ":wb_we"}, {reg_we, pc_we}, {exp_rwe, 1'b1});
    inst_valid = 1'b0;
    @(negedge clk);
    chk({tag, ":post_we"}, {reg_we, pc_we}, 2'b00);
    chk({tag, ":post_rdy"}, inst_ready, 1);
  endtask

  // Drive one instruction expected to stop in DECODE; returns after the HALT state is visible.
  task automatic run_halt(input string tag, input logic [31:0] ins);
    @(negedge clk);
    inst_valid = 1'b1;
    inst       = ins;
    @(posedge clk);
    #1 inst_valid = 1'b0;
    @(negedge clk);
    chk({tag, ":dec_halt"}, halt, 0);
    @(negedge clk);
    chk({tag, ":halt"}, halt, 1);
    chk({tag, ":hold"}, {inst_ready, reg_we, pc_we}, 3'b000);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", inst_ready, 1);
    chk("rst_we", {reg_we, pc_we, jump}, 3'b000);
    chk("rst_halt", {halt, illegal}, 2'b00);
    chk("rst_retired", retired, 0);
    chk("rst_type", typ, 0);
    chk("rst_imm", imm, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_ready", inst_ready, 1);
    end

    run_inst("addi", 32'hFFF0_0293, 1'b1);
    chk("addi_rd", rd, 5);
    chk("addi_alu", {aluc, m1, m2, wb_sel}, {4'd0, 3'b100});
    chk("addi_type", typ, 1);
    chk("addi_imm", imm, 32'hFFFF_FFFF);
    chk("addi_ret", retired, 1);

    run_inst("srai", 32'h4030_D093, 1'b1);
    chk("srai_alu", aluc, 8);
    chk("srai_regs", {rd, rs1}, {5'd1, 5'd1});
    chk("srai_imm", imm, 32'h0000_0403);
    chk("srai_ret", retired, 2);

    run_inst("jal", 32'h0080_00EF, 1'b1);
    chk("jal_type", typ, 3);
    chk("jal_ctl", {jump, wb_sel, m1, m2}, 4'b1111);
    chk("jal_alu", aluc, 0);
    chk("jal_imm", imm, 8);
    chk("jal_ret", retired, 3);

    run_inst("nop", 32'h0000_0013, 1'b0);
    chk("nop_ret", retired, 4);

    run_inst("lui", 32'h1234_5137, 1'b1);
    chk("lui_type", typ, 2);
    chk("lui_alu", {aluc, m1, m2}, {4'd9, 2'b10});
    chk("lui_imm", imm, 32'h1234_5000);
    chk("lui_rd", rd, 2);
    chk("lui_ret", retired, 5);

    run_inst("auipc", 32'h0000_1197, 1'b1);
    chk("auipc_type", typ, 2);
    chk("auipc_alu", {aluc, m1, m2}, {4'd0, 2'b11});
    chk("auipc_imm", imm, 32'h0000_1000);
    chk("auipc_ret", retired, 6);

    run_inst("jalr", 32'h0001_00E7, 1'b1);
    chk("jalr_type", typ, 1);
    chk("jalr_ctl", {jump, wb_sel, m1, m2}, 4'b1110);
    chk("jalr_rs1", rs1, 2);
    chk("jalr_ret", retired, 7);

    run_inst("wrap", 32'hFFF0_0293, 1'b1);
    chk("wrap_ret", retired, 0);

    // reset sampled while the instruction sits in EXEC
    @(negedge clk);
    inst_valid = 1'b1;
    inst       = 32'hFFF0_0293;
    @(posedge clk);
    #1 inst_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rstx_exec_we", {reg_we, pc_we}, 2'b00);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rstx_we", {reg_we, pc_we}, 2'b00);
    chk("rstx_ready", inst_ready, 1);
    chk("rstx_ir", {typ, rd}, 8'h00);
    chk("rstx_imm", imm, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rstx_quiet", {reg_we, pc_we}, 2'b00);
    end
    chk("rstx_ret", retired, 0);

    run_inst("pre_ill", 32'hFFF0_0293, 1'b1);
    run_halt("ill", 32'h4230_D093);
    chk("ill_flag", illegal, 1);
    chk("ill_ret", retired, 1);

    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("ill_rst", {halt, illegal, inst_ready}, 3'b001);

    run_inst("pre_ebk", 32'hFFF0_0293, 1'b1);
    run_halt("ebk", 32'h0010_0073);
    chk("ebk_flag", illegal, 0);
    chk("ebk_ret", retired, 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      inst_valid = i[0] ? 1'b0 : 1'b1;
      inst       = 32'hFFF0_0293;
      chk("ebk_absorb", {halt, inst_ready, reg_we, pc_we}, 4'b1000);
    end
    inst_valid = 1'b0;
    @(negedge clk);
    chk("ebk_frozen", retired, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("ebk_rst", {halt, illegal, inst_ready}, 3'b001);
    chk("ebk_rst_ret", retired, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
